// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int INST_W     = 16;
  localparam int OP_HI      = 15;
  localparam int OP_LO      = 12;

  localparam logic [3:0]        OP_HALT  = 4'b1111;
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [INST_W-1:0]     block_t;

  typedef struct packed {
    addr_t  pc;
    block_t inst;
  } Inst;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [INST_W-1:0] word);
    return word[OP_HI:OP_LO] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, inst} hold register that parks a word fetched while decode stalls.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [15:0]       load_inst,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       inst
);

  // clear wins over load: a redirect must never leave a stale word parked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= NOP_INST;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to imem, feeds decode one {pc, inst} per cycle.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 do_branch,
  input  logic [ADDR_W-1:0]    branch_address,
  input  logic                 do_jump,
  input  logic [ADDR_W-1:0]    jump_address,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_ack,
  input  logic [15:0]          imem_rdata,
  output logic [ADDR_W+15:0]   to_inst,
  output logic                 halted,
  output logic [1:0]           state_dbg
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_flushed
`endif
);

  // imem handshake: a transfer happens in any cycle where imem_req && imem_ack;
  // imem_addr stays stable while imem_req is high and no ack has been seen.
  fetch_state_t        state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [ADDR_W-1:0]   drop_addr, drop_addr_nxt;
  logic [ADDR_W+15:0]  to_inst_nxt;
  logic                req_int, ack, redirect;
  logic [ADDR_W-1:0]   target;
  logic                skid_load, skid_clear, skid_valid;
  logic [ADDR_W-1:0]   skid_pc;
  logic [15:0]         skid_inst;
  logic                issue, flush;

  assign redirect = do_branch | do_jump;
  assign target   = do_branch ? branch_address : jump_address;
  assign ack      = imem_ack & req_int;

  fetch_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_pc   (pc),
    .load_inst (imem_rdata),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (redirect)                         state_nxt = ack ? S_FETCH : S_DROP;
        else if (ack && stall)                state_nxt = S_HOLD;
        else if (ack && is_halt(imem_rdata))  state_nxt = S_HALT;
      end
      S_HOLD: begin
        if (redirect)    state_nxt = S_FETCH;
        else if (!stall) state_nxt = is_halt(skid_inst) ? S_HALT : S_FETCH;
      end
      S_DROP:  if (ack)      state_nxt = S_FETCH;
      S_HALT:  if (redirect) state_nxt = S_FETCH;
      default:               state_nxt = S_FETCH;
    endcase
  end

  // Request is dropped combinationally by reset so an in-flight access dies at once.
  always_comb begin
    req_int   = (state == S_FETCH) || (state == S_DROP);
    imem_req  = rst & req_int;
    imem_addr = (state == S_DROP) ? drop_addr : pc;
    halted    = (state == S_HALT);
    state_dbg = state;
  end

  always_comb begin
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    to_inst_nxt   = {pc, NOP_INST};
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    issue         = 1'b0;
    flush         = 1'b0;
    case (state)
      S_FETCH: begin
        if (redirect) begin
          pc_nxt        = target;
          drop_addr_nxt = pc;
          skid_clear    = 1'b1;
          flush         = ack;
        end else if (stall) begin
          to_inst_nxt = to_inst;
          if (ack) begin
            skid_load = 1'b1;
            pc_nxt    = pc + 1'b1;
          end
        end else if (ack) begin
          to_inst_nxt = {pc, imem_rdata};
          pc_nxt      = pc + 1'b1;
          issue       = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nxt     = target;
          skid_clear = 1'b1;
        end else if (stall) begin
          to_inst_nxt = to_inst;
        end else begin
          to_inst_nxt = {skid_pc, skid_inst};
          skid_clear  = 1'b1;
          issue       = skid_valid;
        end
      end
      S_DROP: begin
        if (redirect) pc_nxt = target;
        flush = ack;
      end
      S_HALT: begin
        if (redirect) pc_nxt = target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      drop_addr <= '0;
      to_inst   <= '0;
    end else begin
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
      to_inst   <= to_inst_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (issue && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      if (flush && perf_flushed != 32'hFFFF_FFFF) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = issue ^ flush;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the key scenarios, then randomized traffic.
module tb_fetch_stage;

  localparam int AW = 16;
  localparam int M_FETCH = 0, M_HOLD = 1, M_DROP = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, do_branch, do_jump, stall, imem_ack;
  logic [AW-1:0] branch_address, jump_address, imem_addr;
  logic          imem_req, halted;
  logic [15:0]   imem_rdata;
  logic [AW+15:0] to_inst;
  logic [1:0]    state_dbg;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_flushed;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+15:0] exp_q[$];

  // reference model state
  int            m_mode;
  logic [AW-1:0] m_pc, m_drop_addr, m_skid_pc;
  logic [15:0]   m_skid_word;
  int unsigned   m_fetched, m_flushed;

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    if (a == 16'h0007) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.ADDR_W(AW), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .do_branch      (do_branch),
    .branch_address (branch_address),
    .do_jump        (do_jump),
    .jump_address   (jump_address),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .to_inst        (to_inst),
    .halted         (halted),
    .state_dbg      (state_dbg)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_FETCH;
    m_pc = 16'h0000;
    m_drop_addr = '0;
    m_skid_pc = '0;
    m_skid_word = '0;
    m_fetched = 0;
    m_flushed = 0;
    exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic          req, ack, redir;
    logic [AW-1:0] tgt;
    logic [15:0]   w;
    req   = (m_mode == M_FETCH) || (m_mode == M_DROP);
    ack   = imem_ack && req;
    redir = do_branch || do_jump;
    tgt   = do_branch ? branch_address : jump_address;
    w     = mem_word(m_pc);
    if (redir) begin
      if (ack) m_flushed++;
      if (m_mode == M_FETCH && !ack) begin
        m_drop_addr = m_pc;
        m_mode = M_DROP;
      end else if (!(m_mode == M_DROP && !ack)) begin
        m_mode = M_FETCH;
      end
      m_pc = tgt;
    end else if (m_mode == M_FETCH) begin
      if (ack) begin
        if (stall) begin
          m_skid_pc = m_pc;
          m_skid_word = w;
          m_mode = M_HOLD;
        end else begin
          exp_q.push_back({m_pc, w});
          m_fetched++;
          if (w[15:12] == 4'hF) m_mode = M_HALT;
        end
        m_pc = m_pc + 16'd1;
      end
    end else if (m_mode == M_HOLD) begin
      if (!stall) begin
        exp_q.push_back({m_skid_pc, m_skid_word});
        m_fetched++;
        m_mode = (m_skid_word[15:12] == 4'hF) ? M_HALT : M_FETCH;
      end
    end else if (m_mode == M_DROP) begin
      if (ack) begin
        m_flushed++;
        m_mode = M_FETCH;
      end
    end
  endtask

  task automatic cyc(input logic s, input logic br, input logic [AW-1:0] ba,
                     input logic jp, input logic [AW-1:0] ja, input logic ak);
    logic exp_req;
    @(negedge clk);
    stall = s;
    do_branch = br;
    branch_address = ba;
    do_jump = jp;
    jump_address = ja;
    imem_ack = ak;
    #1;
    exp_req = (m_mode == M_FETCH) || (m_mode == M_DROP);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, (m_mode == M_DROP) ? m_drop_addr : m_pc);
    check("halted", halted, m_mode == M_HALT);
    @(posedge clk);
    model_step();
  endtask

  task automatic ack_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  // Monitor: every newly presented real instruction must match the next expected one.
  initial begin : monitor
    logic [AW+15:0] last;
    logic [AW+15:0] e;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && to_inst !== last && to_inst[15:0] !== 16'h0000) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL issue: unexpected %0h with empty queue at %0t", to_inst, $time);
        end else begin
          e = exp_q.pop_front();
          check("issue", to_inst, e);
        end
      end
      last = to_inst;
    end
  end

  initial begin : driver
    rst = 1'b0;
    stall = 1'b0;
    do_branch = 1'b0;
    do_jump = 1'b0;
    branch_address = '0;
    jump_address = '0;
    imem_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset to_inst", to_inst, '0);
    check("reset imem_req", imem_req, 1'b0);
    check("reset halted", halted, 1'b0);
    rst = 1'b1;

    // back-to-back fetch from reset: pc 0..4
    ack_n(5);
    // two-cycle stall while pc 5 is acked, then release
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    // pc 6, then halt word at pc 7; idle while halted
    ack_n(2);
    ack_n(4);
    // branch restarts fetch at 0x02
    cyc(1'b0, 1'b1, 16'h0002, 1'b0, '0, 1'b0);
    ack_n(2);
    // jump coinciding with ack
    cyc(1'b0, 1'b0, '0, 1'b1, 16'h0040, 1'b1);
    ack_n(2);
    // branch + jump with the ack delayed three cycles
    cyc(1'b0, 1'b1, 16'h0020, 1'b1, 16'h0030, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    ack_n(2);
`ifdef FETCH_PERF_EN
    @(negedge clk);
    check("perf_flushed", perf_flushed, m_flushed);
`endif
    // pc wrap
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0, '0, 1'b0);
    ack_n(3);
    // reset asserted while a request is outstanding
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async to_inst", to_inst, '0);
    check("async imem_req", imem_req, 1'b0);
    check("async halted", halted, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ack_n(3);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) == 0,
          $urandom_range(0, 99) < 4, 16'($urandom_range(0, 15)),
          $urandom_range(0, 99) < 4, 16'($urandom_range(0, 15)),
          $urandom_range(0, 9) < 6);
    end
    // drain anything parked, without new fetches
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("drain queue", exp_q.size(), 0);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_flushed end", perf_flushed, m_flushed);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
